param_fetch_queue: RTL

- Next-generation instruction fetch stage, parametrised in PC width, instruction width and prefetch depth.
- Issues sequential requests to a synchronous instruction memory and buffers returned words, tagged with their PC, in a DEPTH-entry prefetch queue.
- Presents the queue head to decode with a valid/ready handshake, and redirects on branch, jump or jr with full flush of queued and in-flight fetches.
- Sits between the PC-select/hazard logic and decode.

---
 rtl/param_fetch_queue.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/param_fetch_queue.sv
// Fetch stage: sequential requests to a synchronous imem, PC-tagged DEPTH-entry prefetch queue, flush on redirect.
// Optional FETCH_STATS_EN adds saturating redirect_cnt / bubble_cnt outputs.
module param_fetch_queue #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               pc_src,
  input  logic [ADDR_W-1:0]        branch_addr,
  input  logic [ADDR_W-1:0]        jump_addr,
  input  logic [ADDR_W-1:0]        jr_addr,
  input  logic                     pc_write,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_data,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_W-1:0]        id_instr,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [$clog2(DEPTH):0]   queue_count
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]              redirect_cnt,
  output logic [15:0]              bubble_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  localparam logic [1:0] SRC_SEQ = 2'b00;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ifpc_q, ifpc_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              redirect;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] target;
  logic [CW:0]       occupancy;

  assign redirect = (pc_src != SRC_SEQ);

  always_comb begin
    target = branch_addr;
    case (pc_src)
      2'b10:   target = jump_addr;
      2'b11:   target = jr_addr;
      default: target = branch_addr;
    endcase
  end

  // The outstanding fetch reserves a slot, so a response can always be pushed.
  assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = reset & pc_write & ~redirect & (occupancy < CAP);
  assign imem_addr   = pc_q;
  assign id_valid    = (count_q != '0) & ~redirect;
  assign push        = inflight_q & ~redirect;
  assign pop         = id_valid & id_ready;
  assign id_instr    = mem_q[rd_ptr_q].instr;
  assign id_pc       = mem_q[rd_ptr_q].pc;
  assign queue_count = count_q;

  always_comb begin
    pc_d       = pc_q;
    ifpc_d     = ifpc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      pc_d     = target;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        inflight_d = 1'b1;
        ifpc_d     = pc_q;
        pc_d       = pc_q + ADDR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ifpc_q     <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      ifpc_q     <= ifpc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q].instr <= imem_data;
        mem_q[wr_ptr_q].pc    <= ifpc_q;
      end
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] redirect_cnt_q;
  logic [15:0] bubble_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      redirect_cnt_q <= '0;
      bubble_cnt_q   <= '0;
    end else begin
      if (redirect && (redirect_cnt_q != 16'hFFFF)) redirect_cnt_q <= redirect_cnt_q + 16'd1;
      if (id_ready && !id_valid && (bubble_cnt_q != 16'hFFFF)) bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign bubble_cnt   = bubble_cnt_q;
`endif

endmodule
